// File: rtl/flit_demux_1to2_pkg.sv
// Shared types for the 1-to-2 flit demultiplexer.
// Flit width is taken from the router globals include.
`include "globalVariable.v"

package flit_demux_1to2_pkg;
    localparam int FLIT_W = `IN_ROUTER_SIZE;
    localparam int CNT_W  = 8;

    typedef logic [FLIT_W-1:0] flit_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;
endpackage

// File: rtl/flit_demux_1to2_flit_queue.sv
// Circular flit FIFO with registered head; storage cleared on reset.
// DEPTH must be a power of two so the pointers wrap naturally.
module flit_queue
    import flit_demux_1to2_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  push,
    input  logic  pop,
    input  flit_t data,
    output flit_t head,
    output logic  full,
    output logic  empty
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    flit_t         mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/globalVariable.v
// Router-wide global definitions shared by all router blocks.
// Flit = 32-bit data/header payload plus 3 control bits.
`ifndef GLOBAL_VARIABLE_V
`define GLOBAL_VARIABLE_V
`define IN_ROUTER_SIZE 35
`endif

// File: rtl/flit_demux_1to2.sv
// 1-to-2 flit demultiplexer feeding two independent output FIFOs.
// Define DEMUX_FLIT_CNT_EN to add the per-port accepted-flit counters.
module flit_demux_1to2
    import flit_demux_1to2_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [`IN_ROUTER_SIZE-1:0] dataIn,
    input  logic                       inValid,
    input  logic                       sel,
    output logic                       inReady,
    output logic [`IN_ROUTER_SIZE-1:0] aOut,
    output logic                       aValid,
    input  logic                       aReady,
    output logic [`IN_ROUTER_SIZE-1:0] bOut,
    output logic                       bValid,
`ifdef DEMUX_FLIT_CNT_EN
    output logic [7:0]                 aCount,
    output logic [7:0]                 bCount,
`endif
    input  logic                       bReady
);
    logic a_full;
    logic a_empty;
    logic b_full;
    logic b_empty;
    logic accept;
    logic push_a;
    logic push_b;

    // Ready looks only at the addressed queue, never at inValid.
    assign inReady = (port_e'(sel) == PORT_B) ? !b_full : !a_full;
    assign accept  = inValid && inReady;
    assign push_a  = accept && (port_e'(sel) == PORT_A);
    assign push_b  = accept && (port_e'(sel) == PORT_B);
    assign aValid  = !a_empty;
    assign bValid  = !b_empty;

    flit_queue #(.DEPTH(DEPTH)) u_queue_a (
        .clk   (clk),
        .reset (reset),
        .push  (push_a),
        .pop   (aReady),
        .data  (dataIn),
        .head  (aOut),
        .full  (a_full),
        .empty (a_empty)
    );

    flit_queue #(.DEPTH(DEPTH)) u_queue_b (
        .clk   (clk),
        .reset (reset),
        .push  (push_b),
        .pop   (bReady),
        .data  (dataIn),
        .head  (bOut),
        .full  (b_full),
        .empty (b_empty)
    );

`ifdef DEMUX_FLIT_CNT_EN
    cnt_t cnt_a;
    cnt_t cnt_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            if (push_a) cnt_a <= cnt_a + 1'b1;
            if (push_b) cnt_b <= cnt_b + 1'b1;
        end
    end

    assign aCount = cnt_a;
    assign bCount = cnt_b;
`endif
endmodule

// File: tb/tb_flit_demux_1to2.sv
// Randomised self-checking bench for flit_demux_1to2 against a queue model.
// Exercises the DEMUX_FLIT_CNT_EN counters when that macro is defined.
module tb_flit_demux_1to2;
    import flit_demux_1to2_pkg::*;

    localparam int DEPTH = 2;
    localparam int W     = $bits(flit_t);

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] dataIn;
    logic         inValid;
    logic         sel;
    logic         inReady;
    logic [W-1:0] aOut;
    logic         aValid;
    logic         aReady;
    logic [W-1:0] bOut;
    logic         bValid;
    logic         bReady;
`ifdef DEMUX_FLIT_CNT_EN
    logic [7:0]   aCount;
    logic [7:0]   bCount;
`endif

    flit_demux_1to2 #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .dataIn  (dataIn),
        .inValid (inValid),
        .sel     (sel),
        .inReady (inReady),
        .aOut    (aOut),
        .aValid  (aValid),
        .aReady  (aReady),
        .bOut    (bOut),
        .bValid  (bValid),
`ifdef DEMUX_FLIT_CNT_EN
        .aCount  (aCount),
        .bCount  (bCount),
`endif
        .bReady  (bReady)
    );

    always #5 clk = ~clk;

    // Reference model: one bounded FIFO per port plus push counters.
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    int           ca;
    int           cb;
    int           nchecks;
    int           nerr;

    function automatic logic [W-1:0] rand_flit();
        return W'({$urandom(), $urandom()});
    endfunction

    function automatic bit model_ready(input logic s);
        return (s ? qb.size() : qa.size()) < DEPTH;
    endfunction

    // Advance one clock, applying the model's view of what the edge does.
    task automatic tick();
        bit           pu;
        bit           pa;
        bit           pb;
        logic         s;
        logic [W-1:0] d;
        pu = inValid && model_ready(sel);
        pa = aReady && qa.size() > 0;
        pb = bReady && qb.size() > 0;
        s  = sel;
        d  = dataIn;
        @(posedge clk);
        #1;
        if (reset) begin
            qa.delete();
            qb.delete();
            ca = 0;
            cb = 0;
        end else begin
            if (pa) void'(qa.pop_front());
            if (pb) void'(qb.pop_front());
            if (pu) begin
                if (s) begin
                    qb.push_back(d);
                    cb = (cb + 1) % 256;
                end else begin
                    qa.push_back(d);
                    ca = (ca + 1) % 256;
                end
            end
        end
    endtask

    task automatic idle();
        inValid = 1'b0;
        aReady  = 1'b0;
        bReady  = 1'b0;
        sel     = 1'b0;
        dataIn  = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        nchecks++;
        if (aValid !== 1'b0 || bValid !== 1'b0) begin
            nerr++;
            $display("FAIL reset_valid: got a=%b b=%b want 0 0", aValid, bValid);
        end
        nchecks++;
        if (aOut !== '0 || bOut !== '0) begin
            nerr++;
            $display("FAIL reset_out: got a=%h b=%h want 0 0", aOut, bOut);
        end
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            nchecks++;
            if (inReady !== 1'b1) begin
                nerr++;
                $display("FAIL reset_ready sel=%0d: got %b want 1", s, inReady);
            end
        end
    endtask

    task automatic test_single_push();
        logic [W-1:0] f;
        f = W'(1);
        sel     = 1'b0;
        dataIn  = f;
        inValid = 1'b1;
        #1;
        nchecks++;
        if (aValid !== 1'b0) begin
            nerr++;
            $display("FAIL latency: got aValid=%b same cycle, want 0", aValid);
        end
        tick();
        inValid = 1'b0;
        #1;
        nchecks++;
        if (aValid !== 1'b1 || aOut !== f || bValid !== 1'b0) begin
            nerr++;
            $display("FAIL single_push: got aV=%b aOut=%h bV=%b want 1 %h 0",
                     aValid, aOut, bValid, f);
        end
        nchecks++;
        if (inReady !== 1'b1) begin
            nerr++;
            $display("FAIL single_ready: got %b want 1", inReady);
        end
    endtask

    task automatic test_full();
        logic [W-1:0] f;
        f       = rand_flit();
        sel     = 1'b0;
        dataIn  = f;
        inValid = 1'b1;
        tick();
        #1;
        nchecks++;
        if (inReady !== 1'b0) begin
            nerr++;
            $display("FAIL full_ready_a: got %b want 0", inReady);
        end
        sel = 1'b1;
        #1;
        nchecks++;
        if (inReady !== 1'b1) begin
            nerr++;
            $display("FAIL full_ready_b: got %b want 1", inReady);
        end
        f      = rand_flit();
        dataIn = f;
        tick();
        inValid = 1'b0;
        #1;
        nchecks++;
        if (bValid !== 1'b1 || bOut !== qb[0] || aOut !== qa[0]) begin
            nerr++;
            $display("FAIL full_b_push: got bV=%b bOut=%h aOut=%h want 1 %h %h",
                     bValid, bOut, aOut, qb[0], qa[0]);
        end
    endtask

    task automatic test_sel_switch();
        inValid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel = i[0];
            #1;
            nchecks++;
            if (inReady !== model_ready(sel)) begin
                nerr++;
                $display("FAIL sel_switch sel=%b: got %b want %b",
                         sel, inReady, model_ready(sel));
            end
        end
        inValid = 1'b0;
    endtask

    task automatic test_pop_full();
        logic [W-1:0] second;
        second  = qa[1];
        sel     = 1'b0;
        dataIn  = rand_flit();
        inValid = 1'b1;
        aReady  = 1'b1;
        #1;
        nchecks++;
        if (inReady !== 1'b0) begin
            nerr++;
            $display("FAIL pop_full_ready: got %b want 0", inReady);
        end
        tick();
        inValid = 1'b0;
        aReady  = 1'b0;
        #1;
        nchecks++;
        if (aValid !== 1'b1 || aOut !== second || qa.size() != 1) begin
            nerr++;
            $display("FAIL pop_full_head: got aV=%b aOut=%h want 1 %h",
                     aValid, aOut, second);
        end
        nchecks++;
        if (inReady !== 1'b1) begin
            nerr++;
            $display("FAIL pop_full_after: got %b want 1", inReady);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] flits[8];
        int           sent;
        int           popa;
        int           popb;
        int           cyc;
        do_reset();
        for (int i = 0; i < 8; i++) flits[i] = rand_flit();
        sent = 0;
        popa = 0;
        popb = 0;
        cyc  = 0;
        while ((sent < 8 || qa.size() > 0 || qb.size() > 0) && cyc < 300) begin
            inValid = (sent < 8);
            sel     = (sent < 8) ? sent[0] : 1'b0;
            dataIn  = (sent < 8) ? flits[sent] : '0;
            aReady  = 1'($urandom_range(0, 1));
            bReady  = 1'($urandom_range(0, 1));
            #1;
            nchecks++;
            if (aValid !== (qa.size() > 0) || bValid !== (qb.size() > 0) ||
                (qa.size() > 0 && aOut !== qa[0]) ||
                (qb.size() > 0 && bOut !== qb[0]) ||
                inReady !== model_ready(sel)) begin
                nerr++;
                $display("FAIL random cyc=%0d: got aV=%b aOut=%h bV=%b bOut=%h rdy=%b want aV=%b bV=%b rdy=%b",
                         cyc, aValid, aOut, bValid, bOut, inReady,
                         qa.size() > 0, qb.size() > 0, model_ready(sel));
            end
            if (aReady && qa.size() > 0) popa++;
            if (bReady && qb.size() > 0) popb++;
            if (inValid && model_ready(sel)) begin
                tick();
                sent++;
            end else begin
                tick();
            end
            cyc++;
        end
        idle();
        nchecks++;
        if (sent != 8 || popa != 4 || popb != 4) begin
            nerr++;
            $display("FAIL random_drain: got sent=%0d popa=%0d popb=%0d want 8 4 4",
                     sent, popa, popb);
        end
`ifdef DEMUX_FLIT_CNT_EN
        nchecks++;
        if (aCount !== 8'(ca) || bCount !== 8'(cb)) begin
            nerr++;
            $display("FAIL random_count: got a=%0d b=%0d want %0d %0d",
                     aCount, bCount, ca, cb);
        end
`endif
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) begin
            inValid = 1'b1;
            sel     = i[0];
            dataIn  = rand_flit();
            tick();
        end
        nchecks++;
        if (aValid !== 1'b1 || bValid !== 1'b1 || inReady !== 1'b0) begin
            nerr++;
            $display("FAIL reset_mid_fill: got aV=%b bV=%b rdy=%b want 1 1 0",
                     aValid, bValid, inReady);
        end
        aReady = 1'b1;
        bReady = 1'b1;
        reset  = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        #1;
        nchecks++;
        if (aValid !== 1'b0 || bValid !== 1'b0 || aOut !== '0 || bOut !== '0) begin
            nerr++;
            $display("FAIL reset_mid: got aV=%b bV=%b aOut=%h bOut=%h want 0 0 0 0",
                     aValid, bValid, aOut, bOut);
        end
`ifdef DEMUX_FLIT_CNT_EN
        nchecks++;
        if (aCount !== 8'd0 || bCount !== 8'd0) begin
            nerr++;
            $display("FAIL reset_mid_count: got a=%0d b=%0d want 0 0", aCount, bCount);
        end
`endif
    endtask

`ifdef DEMUX_FLIT_CNT_EN
    task automatic test_count_wrap();
        do_reset();
        bReady  = 1'b1;
        inValid = 1'b1;
        sel     = 1'b1;
        for (int i = 0; i < 257; i++) begin
            dataIn = rand_flit();
            tick();
        end
        idle();
        #1;
        nchecks++;
        if (bCount !== 8'd1 || aCount !== 8'd0 || cb != 1) begin
            nerr++;
            $display("FAIL count_wrap: got a=%0d b=%0d want 0 1", aCount, bCount);
        end
    endtask
`endif

    initial begin
        nchecks = 0;
        nerr    = 0;
        ca      = 0;
        cb      = 0;
        reset   = 1'b1;
        idle();
        test_reset();
        test_single_push();
        test_full();
        test_sel_switch();
        test_pop_full();
        test_random();
        test_reset_mid();
`ifdef DEMUX_FLIT_CNT_EN
        test_count_wrap();
`endif
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule

// File: doc/flit_demux_1to2.md
FLIT_DEMUX_1TO2 -- requirements
Module: flit_demux_1to2

Interface
REQ-001 Parameter: DEPTH, default 2, entries per output queue; power of two, >= 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 dataIn  input  `IN_ROUTER_SIZE  incoming flit (data + header + 3 control bits), carried opaquely.
REQ-005 inValid  input  1  dataIn/sel valid this cycle.
REQ-006 sel  input  1  destination select: 0 -> port A, 1 -> port B.
REQ-007 inReady  output  1  block accepts the flit this cycle.
REQ-008 aOut / bOut  output  `IN_ROUTER_SIZE each  head flit of queue A / B.
REQ-009 aValid / bValid  output  1 each  queue A / B non-empty.
REQ-010 aReady / bReady  input  1 each  downstream consumes head of A / B.
REQ-011 aCount / bCount  output  8 each  accepted-flit counters; present only with DEMUX_FLIT_CNT_EN.

Function
REQ-012 inReady SHALL equal NOT full of the queue addressed by sel, combinationally; independent of inValid.
REQ-013 Push SHALL occur iff inValid && inReady; flit written to queue[sel] only; other queue untouched.
REQ-014 Latency SHALL be one cycle: flit pushed in cycle N visible on xOut/xValid in cycle N+1 at earliest; no combinational in-to-out path.
REQ-015 Pop of queue X SHALL occur iff xValid && xReady; next entry (or xValid=0) presented the following cycle.
REQ-016 xValid SHALL be 1 iff occupancy of X > 0; xOut SHALL be the oldest unpopped flit of X.
REQ-017 Per-queue order SHALL be strictly FIFO; no ordering relation between A and B.
REQ-018 Each queue: read/write pointers of log2(DEPTH) bits, occupancy counter of log2(DEPTH)+1 bits; pointers wrap modulo DEPTH.
REQ-019 Simultaneous push and pop on same non-full, non-empty queue SHALL leave occupancy unchanged and advance both pointers.
REQ-020 Full queue with pop in same cycle SHALL still deassert inReady for that sel (no pass-through); push rejected that cycle.
REQ-021 Empty queue with push in same cycle: no pop possible (xValid=0); occupancy becomes 1.
REQ-022 xReady while xValid=0 SHALL have no effect; inValid while inReady=0 SHALL have no effect; upstream holds dataIn/sel stable until accepted.
REQ-023 sel changing while inValid held SHALL re-evaluate inReady against the newly addressed queue.

Reset
REQ-024 reset=1 at a clock edge SHALL clear pointers, occupancies and storage; next cycle aValid=bValid=0, aOut=bOut=0.
REQ-025 inReady SHALL be 1 for either sel value in the cycle after reset deassertion.
REQ-026 Reset mid-operation SHALL discard all queued flits; a push or pop coinciding with reset SHALL be ignored.

Configuration
REQ-027 Macro DEMUX_FLIT_CNT_EN defined: aCount/bCount exist, increment by 1 per push to that queue, wrap 255 -> 0, reset to 0.
REQ-028 Macro undefined: aCount/bCount ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-029 `IN_ROUTER_SIZE SHALL come from the shared globals include (globalVariable.v); no local redefinition; DEPTH stays a module parameter.
REQ-030 One sub-module, flit_queue (parameterised DEPTH, push/pop/full/empty/head), instantiated twice for A and B; select logic in top.

Verification
REQ-031 Reset, then push 0x...01 (sel=0), aReady=0 -> cycle N+1 aValid=1, aOut=0x...01, bValid=0, inReady=1.
REQ-032 aReady=0, push 2 flits sel=0 (DEPTH=2) -> inReady=0 for sel=0, 1 for sel=1; third flit to B accepted.
REQ-033 Queue A full, aReady=1 and inValid sel=0 same cycle -> pop occurs, push rejected, occupancy 1, next cycle inReady=1.
REQ-034 Interleave 8 flits alternating sel, random x Ready backpressure -> each port outputs its flits in push order, none lost or duplicated.
REQ-035 Assert reset with both queues holding 2 flits and active push/pop -> next cycle both xValid=0, xOut=0; counters 0 if DEMUX_FLIT_CNT_EN.
REQ-036 DEMUX_FLIT_CNT_EN: 257 pushes to B -> bCount=1, aCount=0.
